present_dec: RTL

PRESENT-80 decryption core. It is the inverse of the PRESENT-80 encryption core: it recovers a 64-bit plaintext from a 64-bit ciphertext under the same 80-bit key. The same key value that encrypts a block here decrypts it. The datapath is iterative, one round per cycle. It first runs the forward key schedule to reach the last round key, then runs 31 inverse rounds while undoing the key schedule. It sits beside the encryption core, with the same start/ready handshake and the same big-endian bit numbering ([0] = MSB).

---
 rtl/present_dec_if.sv | 18 +
 rtl/present_dec.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/present_dec_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : present_dec_if                                                   |
// | Brief   : Start/ready handshake and data bus of the PRESENT-80 decryptor.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface present_dec_if;
    logic        sta;
    logic [0:63] inp;
    logic [0:79] key;
    logic        bsy;
    logic        rdy;
    logic [0:63] out;

    modport master (output sta, inp, key, input bsy, rdy, out);
    modport slave  (input sta, inp, key, output bsy, rdy, out);
endinterface
`default_nettype wire

// File: rtl/present_dec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : present_dec                                                      |
// | Brief   : Iterative PRESENT-80 decryption core, one round per cycle.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module present_dec (
    input  wire logic       ck,
    input  wire logic       rst,
    present_dec_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KEXP = 2'd1,
        ST_DEC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [0:4] C_CNT_FIRST = 5'd1;
    localparam logic [0:4] C_CNT_LAST  = 5'd31;

    function automatic logic [0:3] sbox(input logic [0:3] x);
        case (x)
            4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
        endcase
    endfunction

    function automatic logic [0:3] inv_sbox(input logic [0:3] x);
        case (x)
            4'h0: inv_sbox = 4'h5;  4'h1: inv_sbox = 4'hE;  4'h2: inv_sbox = 4'hF;  4'h3: inv_sbox = 4'h8;
            4'h4: inv_sbox = 4'hC;  4'h5: inv_sbox = 4'h1;  4'h6: inv_sbox = 4'h2;  4'h7: inv_sbox = 4'hD;
            4'h8: inv_sbox = 4'hB;  4'h9: inv_sbox = 4'h4;  4'hA: inv_sbox = 4'h6;  4'hB: inv_sbox = 4'h3;
            4'hC: inv_sbox = 4'h0;  4'hD: inv_sbox = 4'h7;  4'hE: inv_sbox = 4'h9;  default: inv_sbox = 4'hA;
        endcase
    endfunction

    function automatic logic [0:79] key_upd(input logic [0:79] k, input logic [0:4] rc);
        logic [0:79] t;
        t        = {k[61:79], k[0:60]};
        t[0:3]   = sbox(t[0:3]);
        t[60:64] = t[60:64] ^ rc;
        return t;
    endfunction

    // Undo key_upd step by step in reverse order; rotate right 61 == rotate left 19.
    function automatic logic [0:79] key_inv(input logic [0:79] k, input logic [0:4] rc);
        logic [0:79] t;
        t        = k;
        t[60:64] = t[60:64] ^ rc;
        t[0:3]   = inv_sbox(t[0:3]);
        return {t[19:79], t[0:18]};
    endfunction

    state_t      st_q,  st_d;
    logic [0:63] s_q,   s_d;
    logic [0:79] k_q,   k_d;
    logic [0:4]  cnt_q, cnt_d;
    logic        bsy_q, bsy_d;
    logic        rdy_q, rdy_d;

    logic [0:79] w_kupd;
    logic [0:79] w_kinv;
    logic [0:63] w_perm;
    logic [0:63] w_invs;

    assign w_kupd = key_upd(k_q, cnt_q);
    assign w_kinv = key_inv(k_q, cnt_q);

    // Inverse pLayer: output bit j takes the bit the forward layer moved to P(j).
    for (genvar j = 0; j < 64; j++) begin : g_invp
        localparam int SRC = (j == 63) ? 63 : (16 * j) % 63;
        assign w_perm[j] = s_q[SRC];
    end

    for (genvar n = 0; n < 16; n++) begin : g_invs
        assign w_invs[4*n +: 4] = inv_sbox(w_perm[4*n +: 4]);
    end

    always_comb begin
        st_d  = st_q;
        s_d   = s_q;
        k_d   = k_q;
        cnt_d = cnt_q;
        case (st_q)
            ST_IDLE, ST_DONE: begin
                if (bus.sta) begin
                    s_d   = bus.inp;
                    k_d   = bus.key;
                    cnt_d = C_CNT_FIRST;
                    st_d  = ST_KEXP;
                end
            end
            ST_KEXP: begin
                k_d = w_kupd;
                if (cnt_q == C_CNT_LAST) begin
                    s_d  = s_q ^ w_kupd[0:63];
                    st_d = ST_DEC;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_DEC: begin
                k_d = w_kinv;
                s_d = w_invs ^ w_kinv[0:63];
                if (cnt_q == C_CNT_FIRST) begin
                    st_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: st_d = ST_IDLE;
        endcase
        bsy_d = (st_d == ST_KEXP) || (st_d == ST_DEC);
        rdy_d = (st_d == ST_DONE);
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            st_q  <= ST_IDLE;
            s_q   <= '0;
            k_q   <= '0;
            cnt_q <= '0;
            bsy_q <= 1'b0;
            rdy_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            s_q   <= s_d;
            k_q   <= k_d;
            cnt_q <= cnt_d;
            bsy_q <= bsy_d;
            rdy_q <= rdy_d;
        end
    end

    assign bus.bsy = bsy_q;
    assign bus.rdy = rdy_q;
    assign bus.out = s_q;

endmodule
`default_nettype wire
